// File: rtl/uart_report_ctrl_pkg.sv
// Shared definitions for the coin-count report streamer: FSM encoding,
// default message length and the ASCII control characters used by the ROM.
package uart_report_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SNAP  = 2'd1,
      ST_FETCH = 2'd2,
      ST_SEND  = 2'd3
   } state_e;

   localparam int unsigned MSG_LEN_DEF = 42;

   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   // Number of clock cycles in one auto-report period.
   function automatic int unsigned tick_top(input int unsigned clk_hz,
                                            input int unsigned period_ms);
      return clk_hz / 1000 * period_ms;
   endfunction

endpackage

// File: rtl/uart_report_tick.sv
// Periodic request generator for the auto-report mode; only instantiated
// when UART_REPORT_AUTO_EN is defined.
module uart_report_tick
   import uart_report_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned PERIOD_MS = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int unsigned TOP   = tick_top(CLK_HZ, PERIOD_MS);
   localparam int          CNT_W = (TOP > 1) ? $clog2(TOP) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic             wrap;

   assign wrap   = (cnt_q == CNT_W'(TOP - 1));
   assign tick_o = wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (wrap) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_report_ctrl.sv
// Streams the coin-count report from the report ROM into the UART TX.
// Define UART_REPORT_AUTO_EN to add a periodic internal report request.
//
//  state | meaning
//  IDLE  | waiting for a request (external, auto tick or pending)
//  SNAP  | snap pulse out, frozen counts settle into the ROM
//  FETCH | latch ROM byte into tx_data, raise tx_valid
//  SEND  | hold byte until TX accepts it
module uart_report_ctrl
   import uart_report_ctrl_pkg::*;
#(
   parameter int unsigned MSG_LEN   = MSG_LEN_DEF,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned PERIOD_MS = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        report_req_i,
   output logic [31:0] rom_addr_o,
   input  logic [7:0]  rom_data_i,
   output logic        snap_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic        done_o
);

   if ((64'd1 << ADDR_W) < 64'(MSG_LEN)) begin : g_bad_addr_w
      $error("ADDR_W too narrow for MSG_LEN");
   end
   if (CLK_HZ < 1000 || PERIOD_MS == 0) begin : g_bad_period
      $error("CLK_HZ must be at least 1 kHz and PERIOD_MS non-zero");
   end

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              pending_q;
   logic              snap_q;
   logic              busy_q;
   logic              done_q;
   logic              tx_valid_q;
   logic [7:0]        tx_data_q;

   logic auto_req;
   logic req_any;
   logic xfer;
   logic last;

`ifdef UART_REPORT_AUTO_EN
   uart_report_tick #(
      .CLK_HZ    (CLK_HZ),
      .PERIOD_MS (PERIOD_MS)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (auto_req)
   );
`else
   assign auto_req = 1'b0;
`endif

   assign req_any = report_req_i | auto_req;
   assign xfer    = tx_valid_q & tx_ready_i;
   assign last    = (addr_q == ADDR_W'(MSG_LEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         pending_q  <= 1'b0;
         snap_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         snap_q <= 1'b0;
         done_q <= 1'b0;
         // Requests outside IDLE (including the done cycle's SEND) are held one deep.
         if (req_any && state_q != ST_IDLE) begin
            pending_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (req_any || pending_q) begin
                  snap_q    <= 1'b1;
                  addr_q    <= '0;
                  pending_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SNAP;
               end
            end
            ST_SNAP: begin
               state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               tx_data_q  <= rom_data_i;
               tx_valid_q <= 1'b1;
               state_q    <= ST_SEND;
            end
            ST_SEND: begin
               if (xfer) begin
                  tx_valid_q <= 1'b0;
                  if (last) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     addr_q  <= '0;
                     state_q <= ST_IDLE;
                  end else begin
                     addr_q  <= addr_q + 1'b1;
                     state_q <= ST_FETCH;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rom_addr_o = {{(32 - ADDR_W){1'b0}}, addr_q};
   assign snap_o     = snap_q;
   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_uart_report_ctrl.sv
// Directed bench for uart_report_ctrl: report ROM model with snapshot
// registers, table of full-report vectors plus hand-written corner sequences.
module tb_uart_report_ctrl;
   import uart_report_ctrl_pkg::*;

   localparam int MSG = 42;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        report_req = 1'b0;
   logic        tx_ready = 1'b0;
   logic [31:0] rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  tx_data;
   logic        snap, tx_valid, busy, done;

   int checks = 0;
   int errors = 0;

   logic [23:0] ten_live = 24'h303030, one_live = 24'h303030;
   logic [23:0] ten_snap = 24'h303030, one_snap = 24'h303030;
   logic [7:0]  got_q[$];
   int          snap_cnt = 0, done_cnt = 0;
   int          rdy_hi = 1, rdy_lo = 0, rdy_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   typedef struct {
      logic [23:0] ten;
      logic [23:0] one;
      int          hi;
      int          lo;
      int          idx;
      logic [7:0]  exp;
   } vec_t;
   vec_t vecs[4];

   uart_report_ctrl #(.MSG_LEN(MSG)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .report_req_i (report_req),
      .rom_addr_o   (rom_addr),
      .rom_data_i   (rom_data),
      .snap_o       (snap),
      .tx_data_o    (tx_data),
      .tx_valid_o   (tx_valid),
      .tx_ready_i   (tx_ready),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   // Message layout: "10baht " + ten count + 27 filler letters + one count + LF CR
   function automatic logic [7:0] msg_byte(input int a, input logic [23:0] ten,
                                           input logic [23:0] one);
      logic [55:0] head;
      head = "10baht ";
      if (a < 7)        return head[8*(6-a) +: 8];
      else if (a < 10)  return ten[8*(9-a) +: 8];
      else if (a < 37)  return 8'(8'h61 + ((a - 10) % 26));
      else if (a < 40)  return one[8*(39-a) +: 8];
      else if (a == 40) return ASCII_LF;
      else if (a == 41) return ASCII_CR;
      else              return 8'hFF;
   endfunction

   assign rom_data = msg_byte(int'(rom_addr), ten_snap, one_snap);

   always @(posedge clk) begin
      if (snap) begin
         ten_snap <= ten_live;
         one_snap <= one_live;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", {31'd0, tx_valid}, 32'd1);
            chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
         end
         chk("addr_range", {31'd0, rom_addr <= 32'd41}, 32'd1);
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         if (snap) snap_cnt++;
         if (done) done_cnt++;
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   always begin
      @(posedge clk);
      #1;
      rdy_cnt  = (rdy_cnt + 1) % (rdy_hi + rdy_lo);
      tx_ready = (rdy_cnt < rdy_hi);
   end

   task automatic clear_mon();
      got_q.delete();
      snap_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic set_ready(input int hi, input int lo);
      rdy_hi  = hi;
      rdy_lo  = lo;
      rdy_cnt = 0;
   endtask

   task automatic pulse_req();
      report_req = 1'b1;
      @(posedge clk); #1;
      report_req = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      int t;
      t = 0;
      while (got_q.size() < n && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("wait_bytes_timeout", {31'd0, got_q.size() >= n}, 32'd1);
   endtask

   task automatic wait_dones(input int n);
      int t;
      t = 0;
      while (done_cnt < n && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("wait_done_timeout", done_cnt, n);
   endtask

   task automatic check_bytes(input int nrep, input logic [23:0] ten, input logic [23:0] one);
      int bad;
      int lim;
      bad = -1;
      chk("transfer_count", got_q.size(), MSG * nrep);
      lim = (got_q.size() < MSG * nrep) ? got_q.size() : MSG * nrep;
      for (int i = 0; i < lim; i++) begin
         if (bad < 0 && got_q[i] !== msg_byte(i % MSG, ten, one)) bad = i;
      end
      chk("byte_stream_first_bad_idx", bad, -1);
   endtask

   task automatic run_report(input vec_t v, input bit chk_timing);
      int  n;
      bit  seen;
      clear_mon();
      ten_live = v.ten;
      one_live = v.one;
      set_ready(v.hi, v.lo);
      @(posedge clk); #1;
      report_req = 1'b1;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 4000) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            report_req = 1'b0;
            chk("snap_pulse", {31'd0, snap}, 32'd1);
            chk("busy_start", {31'd0, busy}, 32'd1);
         end
         if (n == 2) begin
            chk("valid_early", {31'd0, tx_valid}, 32'd0);
            chk("snap_one_cycle", {31'd0, snap}, 32'd0);
            ten_live = 24'h393939;
            one_live = 24'h393939;
         end
         if (n == 3) chk("first_valid_latency", {31'd0, tx_valid}, 32'd1);
         if (done) seen = 1'b1;
      end
      chk("done_seen", {31'd0, seen}, 32'd1);
      if (chk_timing) chk("done_latency", n, 86);
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("busy_end", {31'd0, busy}, 32'd0);
      chk("done_count", done_cnt, 1);
      chk("snap_count", snap_cnt, 1);
      check_bytes(1, v.ten, v.one);
      if (got_q.size() > v.idx) chk("spot_byte", {24'd0, got_q[v.idx]}, {24'd0, v.exp});
      else chk("spot_byte_missing", got_q.size(), v.idx + 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_rom_addr", rom_addr, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_snap", {31'd0, snap}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t;
      vecs[0] = '{ten: 24'h303033, one: 24'h303132, hi: 1, lo: 0, idx: 39, exp: 8'h32};
      vecs[1] = '{ten: 24'h303033, one: 24'h303132, hi: 1, lo: 7, idx: 9,  exp: 8'h33};
      vecs[2] = '{ten: 24'h313230, one: 24'h303435, hi: 2, lo: 3, idx: 37, exp: 8'h30};
      vecs[3] = '{ten: 24'h393939, one: 24'h303030, hi: 1, lo: 1, idx: 41, exp: 8'h0D};

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) run_report(vecs[i], vecs[i].lo == 0);

      // tx_ready high while idle must not produce transfers
      clear_mon();
      set_ready(1, 0);
      repeat (6) @(posedge clk);
      #1;
      chk("idle_ready_ignored", got_q.size(), 0);
      chk("idle_valid_low", {31'd0, tx_valid}, 32'd0);

      // requests while busy merge into one pending report
      clear_mon();
      ten_live = vecs[0].ten;
      one_live = vecs[0].one;
      pulse_req();
      wait_bytes(10);
      pulse_req();
      wait_bytes(20);
      pulse_req();
      wait_dones(2);
      repeat (10) @(posedge clk);
      #1;
      chk("pend_done_count", done_cnt, 2);
      chk("pend_snap_count", snap_cnt, 2);
      chk("pend_busy_end", {31'd0, busy}, 32'd0);
      check_bytes(2, vecs[0].ten, vecs[0].one);

      // request coincident with done
      clear_mon();
      pulse_req();
      t = 0;
      while (!done && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk("done_cycle_found", {31'd0, done}, 32'd1);
      report_req = 1'b1;
      for (n = 1; n <= 3; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            report_req = 1'b0;
            chk("done_req_snap", {31'd0, snap}, 32'd1);
         end
         if (n == 2) chk("done_req_valid_early", {31'd0, tx_valid}, 32'd0);
         if (n == 3) chk("done_req_first_valid", {31'd0, tx_valid}, 32'd1);
      end
      wait_dones(2);
      @(posedge clk); #1;
      chk("done_req_snap_count", snap_cnt, 2);
      check_bytes(2, vecs[0].ten, vecs[0].one);

      // reset mid-message aborts and clears a pending request
      clear_mon();
      pulse_req();
      wait_bytes(10);
      pulse_req();
      wait_bytes(25);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      chk("abort_bytes", got_q.size(), 25);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      snap_cnt = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      chk("abort_pending_cleared", snap_cnt, 0);
      chk("abort_idle", {31'd0, busy}, 32'd0);
      run_report(vecs[0], 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
